// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and defaults for the unified memory arbiter.
//               Holds the response-owner state encoding and the default
//               address/data widths used by the arbiter and its interface.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    // Owner of the response that returns in the following cycle
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP_IF  = 2'd1,
        ST_RESP_LSU = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch (if_*), load/store (lsu_*) and memory
//               (mem_*) channels of the unified memory arbiter.
//               slave  - arbiter view (accepts requests, drives memory)
//               master - environment view (requesters and memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    // Fetch channel
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store channel
    logic              lsu_valid;
    logic              lsu_ready;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    // Memory command channel
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_valid, if_addr,
        input  lsu_valid, lsu_we, lsu_addr, lsu_wdata,
        input  mem_rdata,
        output if_ready, if_rvalid, if_rdata,
        output lsu_ready, lsu_rvalid, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_valid, if_addr,
        output lsu_valid, lsu_we, lsu_addr, lsu_wdata,
        output mem_rdata,
        input  if_ready, if_rvalid, if_rdata,
        input  lsu_ready, lsu_rvalid, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_stats.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_stats
// Description : Free-running statistics counters for the memory arbiter:
//               fetch grants, load/store grants and conflict cycles (both
//               requesters valid). Counters clear on reset and wrap.
// Ports       : clk, rst_n          - clock, async active-low reset
//               if_grant, lsu_grant - one-cycle grant strobes
//               conflict            - both requesters valid this cycle
//               stat_*              - counter values
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_grant,
    input  logic             lsu_grant,
    input  logic             conflict,
    output logic [CNT_W-1:0] stat_if_grants,
    output logic [CNT_W-1:0] stat_lsu_grants,
    output logic [CNT_W-1:0] stat_conflicts
);

    logic [CNT_W-1:0] r_if_grants;
    logic [CNT_W-1:0] r_lsu_grants;
    logic [CNT_W-1:0] r_conflicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_grants  <= '0;
            r_lsu_grants <= '0;
            r_conflicts  <= '0;
        end else begin
            if (if_grant)  r_if_grants  <= r_if_grants  + 1'b1;
            if (lsu_grant) r_lsu_grants <= r_lsu_grants + 1'b1;
            if (conflict)  r_conflicts  <= r_conflicts  + 1'b1;
        end
    end

    assign stat_if_grants  = r_if_grants;
    assign stat_lsu_grants = r_lsu_grants;
    assign stat_conflicts  = r_conflicts;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-ported unified memory between the fetch unit
//               (IF) and the load/store unit (LSU). One command per cycle,
//               LSU has priority unless IF has been denied STARVE_MAX
//               consecutive cycles. Read data (1-cycle latency) is routed
//               back to the requester that owned the command.
// Ports       : clk, rst_n - clock, async active-low reset
//               bus        - mem_arbiter_if.slave (if_*, lsu_*, mem_*)
//               stat_*     - grant/conflict counters (MEM_ARB_STATS_EN only)
// Config      : MEM_ARB_STATS_EN - adds the statistics counters and ports
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_if_grants,
    output logic [CNT_W-1:0] stat_lsu_grants,
    output logic [CNT_W-1:0] stat_conflicts
`endif
);

    localparam int          SC_W     = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] C_SMAX = SC_W'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [SC_W-1:0]   w_starve_nxt;
    logic              r_lsu_we;
    logic              w_if_win;
    logic              w_lsu_win;
    logic [ADDR_W-1:0] w_addr;

    // ------------------------------------------------------------------
    // Grant. Nothing is granted while reset is asserted so no command
    // escapes to memory before the response FSM is live.
    // ------------------------------------------------------------------
    always_comb begin
        w_if_win  = 1'b0;
        w_lsu_win = 1'b0;
        if (rst_n) begin
            w_if_win  = bus.if_valid && (!bus.lsu_valid || (r_starve_cnt == C_SMAX));
            w_lsu_win = bus.lsu_valid && !w_if_win;
        end
    end

    always_comb begin
        w_addr = '0;
        if (w_lsu_win)     w_addr = bus.lsu_addr;
        else if (w_if_win) w_addr = bus.if_addr;
    end

    assign bus.if_ready  = w_if_win;
    assign bus.lsu_ready = w_lsu_win;
    assign bus.mem_req   = w_if_win || w_lsu_win;
    assign bus.mem_we    = w_lsu_win && bus.lsu_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = (w_lsu_win && bus.lsu_we) ? bus.lsu_wdata : {DATA_W{1'b0}};

    // ------------------------------------------------------------------
    // Response owner FSM: next state is whoever was granted this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_if_win)       w_state_nxt = ST_RESP_IF;
        else if (w_lsu_win) w_state_nxt = ST_RESP_LSU;
    end

    // Starvation counter: only counts while IF is actively being refused
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!bus.if_valid || w_if_win)  w_starve_nxt = '0;
        else if (r_starve_cnt != C_SMAX) w_starve_nxt = r_starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_lsu_we     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_lsu_we     <= w_lsu_win && bus.lsu_we;
        end
    end

    // Store acknowledges return zero data rather than stale memory output
    assign bus.if_rvalid  = (r_state == ST_RESP_IF);
    assign bus.if_rdata   = (r_state == ST_RESP_IF) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.lsu_rvalid = (r_state == ST_RESP_LSU);
    assign bus.lsu_rdata  = ((r_state == ST_RESP_LSU) && !r_lsu_we) ? bus.mem_rdata
                                                                     : {DATA_W{1'b0}};

`ifdef MEM_ARB_STATS_EN
    mem_arbiter_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_grant        (w_if_win),
        .lsu_grant       (w_lsu_win),
        .conflict        (rst_n && bus.if_valid && bus.lsu_valid),
        .stat_if_grants  (stat_if_grants),
        .stat_lsu_grants (stat_lsu_grants),
        .stat_conflicts  (stat_conflicts)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A table of per-cycle
//               request vectors with expected grants is applied; expected
//               responses are pushed to a scoreboard on each expected grant
//               and compared one cycle later. A 64-word memory with
//               1-cycle read latency sits on the mem_* channel.
// Config      : MEM_ARB_STATS_EN - also checks the statistics ports
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic          rst_n;
        logic          if_v;
        logic [AW-1:0] if_addr;
        logic          lsu_v;
        logic          lsu_we;
        logic [AW-1:0] lsu_addr;
        logic [DW-1:0] lsu_wdata;
        logic          exp_if;
        logic          exp_lsu;
    } vec_t;

    typedef struct {
        logic          is_if;
        logic [DW-1:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_lsu_grants, stat_conflicts;
`endif

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
`ifdef MEM_ARB_STATS_EN
        ,
        .CNT_W      (32)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants  (stat_if_grants),
        .stat_lsu_grants (stat_lsu_grants),
        .stat_conflicts  (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Memory: write on the edge, read data registered (1-cycle latency)
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    always @(posedge clk) begin
        if (bus.mem_req) begin
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        end
    end

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t sb[$];
    vec_t  tbl[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic [AW-1:0] ia,
                                input logic lv, input logic lw, input logic [AW-1:0] la,
                                input logic [DW-1:0] ld, input logic ei, input logic el);
        vec_t v;
        v.rst_n = r;   v.if_v = iv;   v.if_addr = ia;
        v.lsu_v = lv;  v.lsu_we = lw; v.lsu_addr = la; v.lsu_wdata = ld;
        v.exp_if = ei; v.exp_lsu = el;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endfunction

    // One cycle: drive on the falling edge, check 1 ns later
    task automatic step(input vec_t v);
        resp_t         e;
        logic          exp_if_rv, exp_lsu_rv;
        logic [DW-1:0] exp_if_d, exp_lsu_d;
        @(negedge clk);
        rst_n         = v.rst_n;
        bus.if_valid  = v.if_v;
        bus.if_addr   = v.if_addr;
        bus.lsu_valid = v.lsu_v;
        bus.lsu_we    = v.lsu_we;
        bus.lsu_addr  = v.lsu_addr;
        bus.lsu_wdata = v.lsu_wdata;
        if (!v.rst_n) sb.delete();
        #1;
        exp_if_rv = 1'b0; exp_lsu_rv = 1'b0; exp_if_d = '0; exp_lsu_d = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_if) begin exp_if_rv  = 1'b1; exp_if_d  = e.data; end
            else         begin exp_lsu_rv = 1'b1; exp_lsu_d = e.data; end
        end
        check("if_rvalid",  DW'(bus.if_rvalid),  DW'(exp_if_rv));
        check("lsu_rvalid", DW'(bus.lsu_rvalid), DW'(exp_lsu_rv));
        if (exp_if_rv)  check("if_rdata",  bus.if_rdata,  exp_if_d);
        if (exp_lsu_rv) check("lsu_rdata", bus.lsu_rdata, exp_lsu_d);

        check("if_ready",  DW'(bus.if_ready),  DW'(v.exp_if));
        check("lsu_ready", DW'(bus.lsu_ready), DW'(v.exp_lsu));
        check("mem_req",   DW'(bus.mem_req),   DW'(v.exp_if | v.exp_lsu));
        if (v.exp_lsu) begin
            check("mem_we",   DW'(bus.mem_we),   DW'(v.lsu_we));
            check("mem_addr", DW'(bus.mem_addr), DW'(v.lsu_addr));
            if (v.lsu_we) check("mem_wdata", bus.mem_wdata, v.lsu_wdata);
            e.is_if = 1'b0;
            if (v.lsu_we) begin
                ref_mem[v.lsu_addr[7:2]] = v.lsu_wdata;
                e.data = '0;
            end else begin
                e.data = ref_mem[v.lsu_addr[7:2]];
            end
            sb.push_back(e);
        end else if (v.exp_if) begin
            check("mem_we",   DW'(bus.mem_we),   '0);
            check("mem_addr", DW'(bus.mem_addr), DW'(v.if_addr));
            e.is_if = 1'b1;
            e.data  = ref_mem[v.if_addr[7:2]];
            sb.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        bus.mem_rdata = '0;
        rst_n = 1'b0;
        bus.if_valid = 1'b0; bus.if_addr = '0;
        bus.lsu_valid = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0;

        // Reset held with both valid: nothing granted; release -> LSU first
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 16'hC, '0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0, 1'b1, 1'b0, 16'hC, '0, 1'b0, 1'b1));
        // IF alone, back to back: words 0 and 1
        tbl.push_back(mk(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h4, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        tbl.push_back(idle());
        // Store then load same word
        tbl.push_back(mk(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h0, 32'h0000_0293, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h0, '0, 1'b0, 1'b1));
        tbl.push_back(idle());
        // Store then fetch same word next cycle (write-first)
        tbl.push_back(mk(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h4, 32'h0000_0295, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 16'h4, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        // Conflict: store wins, the held fetch sees the new word next cycle
        tbl.push_back(mk(1'b1, 1'b1, 16'h8, 1'b1, 1'b1, 16'h8, 32'hDEAD_BEEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 16'h8, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        tbl.push_back(idle());
        // Continuous conflict: LSU x4, IF, LSU x4, IF
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b1, 1'b1, 16'h20, 1'b1, 1'b0, 16'(16 + 4 * i), '0,
                             (i == 4 || i == 9), !(i == 4 || i == 9)));
        tbl.push_back(idle());

        foreach (tbl[i]) step(tbl[i]);

        // Reset for one cycle right after a load grant: response is dropped
        step(mk(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h14, '0, 1'b0, 1'b1));
        step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        step(idle());
        step(idle());
`ifdef MEM_ARB_STATS_EN
        check("stat_if_grants",  stat_if_grants,  '0);
        check("stat_lsu_grants", stat_lsu_grants, '0);
        check("stat_conflicts",  stat_conflicts,  '0);
`endif
        // Normal operation resumes after the reset
        step(mk(1'b1, 1'b1, 16'h10, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        step(idle());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
